// File: rtl/keypad_debounce_controller.sv
// Keypad front end: synchronizes raw key lines, arbitrates the lowest pressed
// key, drives a shared external debounce delay, hands the accepted key code to
// a valid/ready consumer and waits for a full release before re-arming.
module keypad_debounce_controller #(
    parameter int unsigned NUM_KEYS       = 10,
    parameter int unsigned TIMEOUT        = 255,
    parameter int unsigned RELEASE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] keys,
    output logic                deb_run,
    input  logic                deb_done,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                busy,
    output logic                timeout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RC_W = $clog2(RELEASE_CYCLES + 1);

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RELEASE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        OUTPUT,
        RELEASE_WAIT
    } state_t;

    // Synchronizer stages; skeys is the only view of the keys used below.
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] skeys;

    state_t              state_q, state_d;
    logic [3:0]          sel_q, sel_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [RC_W-1:0]     rel_q, rel_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                timeout_err_d;

    logic                deb_run_q;
    logic                key_valid_q;
    logic                busy_q;
    logic                timeout_err_q;

    // Derived views of the synchronized keys
    logic                any_key;
    logic [3:0]          first_idx;
    logic                sel_hit;
    logic [WD_W-1:0]     wd_inc;
    logic [RC_W-1:0]     rel_inc;

    assign skeys = sync2_q;

    // Two-flop synchronizer for the asynchronous key lines
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
        end
    end

    // Lowest-index pressed key, and whether the latched key is still down
    always_comb begin
        any_key   = 1'b0;
        first_idx = '0;
        sel_hit   = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (skeys[i] && !any_key) begin
                any_key   = 1'b1;
                first_idx = 4'(i);
            end
            if (4'(i) == sel_q) begin
                sel_hit = skeys[i];
            end
        end
    end

    // Saturating increments for the watchdog and release counters
    always_comb begin
        wd_inc  = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        rel_inc = (rel_q == RC_MAX) ? rel_q : rel_q + RC_W'(1);
    end

    // Next-state and datapath decisions
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        wd_d          = wd_q;
        rel_d         = rel_q;
        key_code_d    = key_code_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_key) begin
                    sel_d   = first_idx;
                    wd_d    = '0;
                    state_d = PRESS_WAIT;
                end
            end

            PRESS_WAIT: begin
                wd_d = wd_inc;
                // deb_done is tested first so it wins over a coincident expiry
                if (deb_done) begin
                    if (sel_hit) begin
                        key_code_d = sel_q;
                        state_d    = OUTPUT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_inc == WD_MAX) begin
                    timeout_err_d = 1'b1;
                    rel_d         = '0;
                    state_d       = RELEASE_WAIT;
                end
            end

            OUTPUT: begin
                // key_valid is high throughout OUTPUT, so ready alone completes
                if (key_ready) begin
                    rel_d   = '0;
                    state_d = RELEASE_WAIT;
                end
            end

            RELEASE_WAIT: begin
                if (any_key) begin
                    rel_d = '0;
                end else begin
                    rel_d = rel_inc;
                    if (rel_inc == RC_MAX) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            wd_q          <= '0;
            rel_q         <= '0;
            key_code_q    <= '0;
            deb_run_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            wd_q          <= wd_d;
            rel_q         <= rel_d;
            key_code_q    <= key_code_d;
            // Outputs are decoded from the next state so they line up with state_q
            deb_run_q     <= (state_d == PRESS_WAIT);
            key_valid_q   <= (state_d == OUTPUT);
            busy_q        <= (state_d != IDLE);
            timeout_err_q <= timeout_err_d;
        end
    end

    assign deb_run     = deb_run_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_keypad_debounce_controller.sv
// Directed self-checking bench for keypad_debounce_controller (default parameters).
module tb_keypad_debounce_controller;

    logic       clock;
    logic       reset_n;
    logic [9:0] keys;
    logic       deb_run;
    logic       deb_done;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    keypad_debounce_controller #(
        .NUM_KEYS(10),
        .TIMEOUT(255),
        .RELEASE_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .keys(keys),
        .deb_run(deb_run),
        .deb_done(deb_done),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; keys = '0; deb_done = 1'b0; key_ready = 1'b0;
        repeat (3) tick();
        checks++; if (deb_run !== 1'b0) begin errors++; $display("FAIL reset_deb_run got=%0b exp=0", deb_run); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got=%0b exp=0", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code got=%0d exp=0", key_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%0b exp=0", timeout_err); end
        reset_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_basic();
        key_ready = 1'b1;
        keys = 10'h008;
        tick(); tick();
        checks++; if (deb_run !== 1'b0) begin errors++; $display("FAIL basic_sync_latency deb_run=%0b exp=0", deb_run); end
        tick();
        checks++; if (deb_run !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_press_wait deb_run=%0b busy=%0b exp=1,1", deb_run, busy); end
        repeat (19) tick();
        checks++; if (deb_run !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL basic_waiting deb_run=%0b key_valid=%0b exp=1,0", deb_run, key_valid); end
        deb_done = 1'b1;
        tick();
        deb_done = 1'b0;
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd3 || deb_run !== 1'b0) begin errors++; $display("FAIL basic_accept valid=%0b code=%0d run=%0b exp=1,3,0", key_valid, key_code, deb_run); end
        tick();
        checks++; if (key_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_handshake valid=%0b busy=%0b exp=0,1", key_valid, busy); end
        checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL basic_code_hold got=%0d exp=3", key_code); end
        keys = '0;
        repeat (17) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_release_early busy=%0b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0 || deb_run !== 1'b0) begin errors++; $display("FAIL basic_release_idle busy=%0b run=%0b exp=0,0", busy, deb_run); end
    endtask

    task automatic test_priority();
        key_ready = 1'b1;
        keys = 10'h084;
        repeat (3) tick();
        checks++; if (deb_run !== 1'b1) begin errors++; $display("FAIL prio_press_wait deb_run=%0b exp=1", deb_run); end
        keys = 10'h085;
        repeat (4) tick();
        deb_done = 1'b1;
        tick();
        deb_done = 1'b0;
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd2) begin errors++; $display("FAIL prio_lowest valid=%0b code=%0d exp=1,2", key_valid, key_code); end
        tick();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL prio_handshake valid=%0b exp=0", key_valid); end
        keys = 10'h080;
        repeat (40) tick();
        checks++; if (busy !== 1'b1 || deb_run !== 1'b0) begin errors++; $display("FAIL prio_held_no_rearm busy=%0b run=%0b exp=1,0", busy, deb_run); end
        keys = '0;
        repeat (17) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_release_early busy=%0b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_release_idle busy=%0b exp=0", busy); end
        keys = 10'h080;
        repeat (3) tick();
        checks++; if (deb_run !== 1'b1) begin errors++; $display("FAIL prio_key7_wait deb_run=%0b exp=1", deb_run); end
        deb_done = 1'b1;
        tick();
        deb_done = 1'b0;
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd7) begin errors++; $display("FAIL prio_key7 valid=%0b code=%0d exp=1,7", key_valid, key_code); end
        tick();
        // A one-cycle bounce inside the release window restarts the count
        keys = '0;
        repeat (10) tick();
        keys = 10'h080;
        tick();
        keys = '0;
        repeat (17) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_glitch_restart busy=%0b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_glitch_idle busy=%0b exp=0", busy); end
    endtask

    task automatic test_bounce();
        key_ready = 1'b1;
        keys = 10'h020;
        repeat (3) tick();
        checks++; if (deb_run !== 1'b1) begin errors++; $display("FAIL bounce_press_wait deb_run=%0b exp=1", deb_run); end
        keys = '0;
        repeat (19) tick();
        deb_done = 1'b1;
        tick();
        deb_done = 1'b0;
        checks++; if (key_valid !== 1'b0 || busy !== 1'b0 || deb_run !== 1'b0) begin errors++; $display("FAIL bounce_reject valid=%0b busy=%0b run=%0b exp=0,0,0", key_valid, busy, deb_run); end
        repeat (5) tick();
        checks++; if (key_valid !== 1'b0 || deb_run !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bounce_stay_idle valid=%0b run=%0b busy=%0b exp=0,0,0", key_valid, deb_run, busy); end
    endtask

    task automatic test_timeout();
        key_ready = 1'b1;
        keys = 10'h002;
        repeat (3) tick();
        checks++; if (deb_run !== 1'b1) begin errors++; $display("FAIL tmo_press_wait deb_run=%0b exp=1", deb_run); end
        repeat (254) tick();
        checks++; if (timeout_err !== 1'b0 || deb_run !== 1'b1) begin errors++; $display("FAIL tmo_early err=%0b run=%0b exp=0,1", timeout_err, deb_run); end
        tick();
        checks++; if (timeout_err !== 1'b1 || deb_run !== 1'b0 || key_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_pulse err=%0b run=%0b valid=%0b busy=%0b exp=1,0,0,1", timeout_err, deb_run, key_valid, busy); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_single err=%0b exp=0", timeout_err); end
        keys = '0;
        repeat (17) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_release_early busy=%0b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_release_idle busy=%0b exp=0", busy); end
    endtask

    task automatic test_done_vs_timeout();
        key_ready = 1'b0;
        keys = 10'h002;
        repeat (3) tick();
        repeat (254) tick();
        deb_done = 1'b1;
        tick();
        deb_done = 1'b0;
        checks++; if (key_valid !== 1'b1 || timeout_err !== 1'b0 || key_code !== 4'd1) begin errors++; $display("FAIL race_done_wins valid=%0b err=%0b code=%0d exp=1,0,1", key_valid, timeout_err, key_code); end
        key_ready = 1'b1;
        tick();
        checks++; if (key_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL race_handshake valid=%0b err=%0b exp=0,0", key_valid, timeout_err); end
        keys = '0;
        repeat (18) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL race_idle busy=%0b exp=0", busy); end
    endtask

    task automatic test_hold();
        int bad;
        key_ready = 1'b0;
        keys = 10'h010;
        repeat (3) tick();
        deb_done = 1'b1;
        tick();
        deb_done = 1'b0;
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd4) begin errors++; $display("FAIL hold_accept valid=%0b code=%0d exp=1,4", key_valid, key_code); end
        keys = '0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (key_valid !== 1'b1 || key_code !== 4'd4) begin
                errors++;
                if (bad < 3) $display("FAIL hold_stable cyc=%0d valid=%0b code=%0d exp=1,4", i, key_valid, key_code);
                bad++;
            end
        end
        key_ready = 1'b1;
        tick();
        checks++; if (key_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_transfer valid=%0b busy=%0b exp=0,1", key_valid, busy); end
        repeat (15) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_release_early busy=%0b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_release_idle busy=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b0;
        keys = 10'h040;
        repeat (3) tick();
        deb_done = 1'b1;
        tick();
        deb_done = 1'b0;
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL rmid_accept valid=%0b code=%0d exp=1,6", key_valid, key_code); end
        reset_n = 1'b0;
        tick();
        checks++; if (key_valid !== 1'b0 || key_code !== 4'd0 || busy !== 1'b0 || deb_run !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs valid=%0b code=%0d busy=%0b run=%0b err=%0b exp=0,0,0,0,0", key_valid, key_code, busy, deb_run, timeout_err);
        end
        reset_n = 1'b1;
        key_ready = 1'b1;
        tick(); tick();
        checks++; if (deb_run !== 1'b0 || key_valid !== 1'b0) begin errors++; $display("FAIL rmid_sync_latency run=%0b valid=%0b exp=0,0", deb_run, key_valid); end
        tick();
        checks++; if (deb_run !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rmid_redetect run=%0b busy=%0b exp=1,1", deb_run, busy); end
        deb_done = 1'b1;
        tick();
        deb_done = 1'b0;
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL rmid_reaccept valid=%0b code=%0d exp=1,6", key_valid, key_code); end
        tick();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rmid_handshake valid=%0b exp=0", key_valid); end
        keys = '0;
        repeat (18) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle busy=%0b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_bounce();
        test_timeout();
        test_done_vs_timeout();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
